// File: rtl/updi_phy_rx_if.sv
// ---------------------------------------------------------------------------
// updi_phy_rx_if
//   Bundles the serial line, the receive enable and the received-frame
//   status of the UPDI PHY receiver.
//
//   Signals
//     ren     receive enable (master -> receiver)
//     prdata  asynchronous UPDI line, idle high (master -> receiver)
//     o_data  last received byte (receiver -> master)
//     rend    one-cycle frame-complete strobe (receiver -> master)
//     perr    parity error on the last frame (receiver -> master)
//     ferr    framing error on the last frame (receiver -> master)
//     busy    receiver is not idle (receiver -> master)
//     brk     one-cycle break-detected strobe (receiver -> master)
//
//   Modports
//     master  link/data layer side: drives ren/prdata, reads status
//     slave   the receiver itself
// ---------------------------------------------------------------------------
interface updi_phy_rx_if;
  logic       ren;
  logic       prdata;
  logic [7:0] o_data;
  logic       rend;
  logic       perr;
  logic       ferr;
  logic       busy;
  logic       brk;

  modport master (
    output ren, prdata,
    input  o_data, rend, perr, ferr, busy, brk
  );

  modport slave (
    input  ren, prdata,
    output o_data, rend, perr, ferr, busy, brk
  );
endinterface

// File: rtl/updi_phy_rx.sv
// ---------------------------------------------------------------------------
// updi_phy_rx
//   Receive half of the UPDI physical layer. Deserializes the single-wire
//   frame on prdata: start bit (0), 8 data bits LSB first, even parity,
//   two stop bits (1). The line idles high. A finished frame is reported
//   with a one-cycle rend strobe together with o_data, perr and ferr.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per UPDI bit (even, >= 4)
//     HALF_BIT      derived, cycles from start edge to the start-bit sample
//
//   Ports
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   updi_phy_rx_if.slave (ren, prdata in; o_data, rend, perr,
//           ferr, busy, brk out)
//
//   Optional feature
//     UPDI_RX_BREAK_DET_EN  when defined, a line held low through the data,
//     parity and first stop bit is treated as a UPDI BREAK: the receiver
//     waits for the line to return high and pulses brk instead of rend.
//     When undefined, brk is tied low and that condition ends as an
//     ordinary frame with a framing error.
// ---------------------------------------------------------------------------
module updi_phy_rx #(
  parameter  int CLKS_PER_BIT = 16,
  localparam int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic         clk,
  input  logic         rst,
  updi_phy_rx_if.slave bus
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UPDI_RX_BREAK_DET_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;
`endif

  state_t        state_q, state_d;
  logic          rx_m, rx_s;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_err_q;
  logic          frame_err_q;
  logic [7:0]    o_data_q;
  logic          perr_q, ferr_q, rend_q, busy_q;
  logic          half_tick, full_tick;
  logic          frame_done;
`ifdef UPDI_RX_BREAK_DET_EN
  logic          brk_hit;
  logic          brk_q;
`endif

  // Mid-bit sample points: half a bit after the start edge, then one full
  // bit apart because the counter restarts at every sample.
  assign half_tick = (clk_cnt_q == HALF_LAST);
  assign full_tick = (clk_cnt_q == FULL_LAST);

  // Next-state decode. Dropping ren aborts from any state on the next edge.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
`ifdef UPDI_RX_BREAK_DET_EN
    brk_hit    = 1'b0;
`endif
    if (!bus.ren) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (!rx_s) state_d = S_START;
        S_START:  if (half_tick) state_d = rx_s ? S_IDLE : S_DATA;
        S_DATA:   if (full_tick && bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: if (full_tick) state_d = S_STOP1;
        S_STOP1: begin
          if (full_tick) begin
            state_d = S_STOP2;
`ifdef UPDI_RX_BREAK_DET_EN
            // With all data bits zero the parity error flag equals the
            // sampled parity bit, so a clear flag means that bit was 0.
            if (shift_q == 8'h00 && !par_err_q && !rx_s) state_d = S_BREAK;
`endif
          end
        end
        S_STOP2: begin
          if (full_tick) begin
            state_d    = S_IDLE;
            frame_done = 1'b1;
          end
        end
`ifdef UPDI_RX_BREAK_DET_EN
        S_BREAK: begin
          if (rx_s) begin
            state_d = S_IDLE;
            brk_hit = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register, synchronizer and datapath. The frame result is
  // published on the edge of the STOP2 sample so rend appears the cycle
  // after it, with the state already back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      o_data_q    <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      rend_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_m    <= bus.prdata;
      rx_s    <= rx_m;
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      rend_q  <= frame_done;

      if (state_q == S_IDLE || (state_q == S_START && half_tick) || full_tick)
        clk_cnt_q <= '0;
      else
        clk_cnt_q <= clk_cnt_q + 1'b1;

      if (state_q != S_DATA)
        bit_cnt_q <= '0;
      else if (full_tick)
        bit_cnt_q <= bit_cnt_q + 3'd1;

      if (state_q == S_DATA && full_tick)
        shift_q <= {rx_s, shift_q[7:1]};

      if (state_q == S_START && half_tick)
        frame_err_q <= 1'b0;

      if (state_q == S_PARITY && full_tick)
        par_err_q <= rx_s ^ (^shift_q);

      if (state_q == S_STOP1 && full_tick && !rx_s)
        frame_err_q <= 1'b1;

      if (frame_done) begin
        o_data_q <= shift_q;
        perr_q   <= par_err_q;
        ferr_q   <= frame_err_q | ~rx_s;
      end
    end
  end

`ifdef UPDI_RX_BREAK_DET_EN
  // One-cycle break strobe, raised when the line finally returns high.
  always_ff @(posedge clk) begin
    if (rst) brk_q <= 1'b0;
    else     brk_q <= brk_hit;
  end
  assign bus.brk = brk_q;
`else
  assign bus.brk = 1'b0;
`endif

  assign bus.o_data = o_data_q;
  assign bus.perr   = perr_q;
  assign bus.ferr   = ferr_q;
  assign bus.rend   = rend_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_updi_phy_rx.sv
// ---------------------------------------------------------------------------
// tb_updi_phy_rx
//   Self-checking bench for updi_phy_rx with CLKS_PER_BIT=4. Frames are
//   built as 12 line levels; the expected byte and flags are decoded from
//   those levels (even parity over data+parity, both stop bits high).
//   Build with +define+UPDI_RX_BREAK_DET_EN to exercise break detection.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_updi_phy_rx;
  localparam int CPB     = 4;
  localparam int NOM_LAT = (23 * CPB) / 2 + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  updi_phy_rx_if bus ();

  updi_phy_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cmp_cnt  = 0;
  int fail_cnt = 0;
  int cyc      = 0;
  int brk_cnt  = 0;

  logic [7:0] exp_data[$];
  bit         exp_perr[$];
  bit         exp_ferr[$];
  int         exp_drop[$];
  logic [7:0] obs_data[$];
  bit         obs_perr[$];
  bit         obs_ferr[$];
  int         obs_cyc[$];

  logic [7:0] last_data = 8'h00;
  bit         last_perr = 1'b0;
  bit         last_ferr = 1'b0;

  // Cycle counter used to time-stamp line edges and strobes.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge away from the DUT's edge.
  always @(negedge clk) begin
    if (bus.rend === 1'b1) begin
      obs_data.push_back(bus.o_data);
      obs_perr.push_back(bus.perr);
      obs_ferr.push_back(bus.ferr);
      obs_cyc.push_back(cyc);
    end
    if (bus.brk === 1'b1) brk_cnt++;
  end

  // Hang guard.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic driveBit(input bit v);
    bus.prdata = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idleBits(input int n);
    bus.prdata = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  // Sends one full frame and records what a receiver must report for it.
  task automatic applyStimulus(input logic [7:0] data, input bit par,
                               input bit s1, input bit s2, input bit chk_busy);
    bit line [12];
    logic [7:0] d;
    line[0] = 1'b0;
    for (int i = 0; i < 8; i++) line[i+1] = data[i];
    line[9]  = par;
    line[10] = s1;
    line[11] = s2;
    d = '0;
    for (int i = 0; i < 8; i++) d[i] = line[i+1];
    exp_data.push_back(d);
    exp_perr.push_back((d[0]+d[1]+d[2]+d[3]+d[4]+d[5]+d[6]+d[7]+line[9]) % 2 == 1);
    exp_ferr.push_back(!(line[10] && line[11]));
    exp_drop.push_back(cyc);
    for (int i = 0; i < 12; i++) begin
      driveBit(line[i]);
      if (chk_busy && i == 4) checkOutput("busy_in_frame", int'(bus.busy), 1);
    end
  endtask

  task automatic checkFrames(input string tag);
    int guard;
    int lat;
    logic [7:0] ed;
    bit ep, ef;
    guard = 0;
    while (obs_data.size() < exp_data.size() && guard < 20 * CPB) begin
      @(negedge clk);
      guard++;
    end
    repeat (2 * CPB) @(negedge clk);
    checkOutput({tag, "_rend_count"}, obs_data.size(), exp_data.size());
    while (exp_data.size() != 0 && obs_data.size() != 0) begin
      ed = exp_data.pop_front();
      ep = exp_perr.pop_front();
      ef = exp_ferr.pop_front();
      lat = obs_cyc.pop_front() - exp_drop.pop_front();
      checkOutput({tag, "_data"}, obs_data.pop_front(), ed);
      checkOutput({tag, "_perr"}, int'(obs_perr.pop_front()), int'(ep));
      checkOutput({tag, "_ferr"}, int'(obs_ferr.pop_front()), int'(ef));
      checkOutput({tag, "_latency_in_tol"},
                  int'(lat >= NOM_LAT - 1 && lat <= NOM_LAT + 1), 1);
      last_data = ed;
      last_perr = ep;
      last_ferr = ef;
    end
    exp_data.delete(); exp_perr.delete(); exp_ferr.delete(); exp_drop.delete();
    obs_data.delete(); obs_perr.delete(); obs_ferr.delete(); obs_cyc.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_o_data"}, bus.o_data, 0);
    checkOutput({tag, "_rend"}, int'(bus.rend), 0);
    checkOutput({tag, "_perr"}, int'(bus.perr), 0);
    checkOutput({tag, "_ferr"}, int'(bus.ferr), 0);
    checkOutput({tag, "_busy"}, int'(bus.busy), 0);
    checkOutput({tag, "_brk"}, int'(bus.brk), 0);
  endtask

  initial begin
    logic [7:0] rd;
    bit rp, r1, r2;

    // Reset state.
    rst = 1'b1;
    bus.ren = 1'b1;
    bus.prdata = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    idleBits(1);

    // Valid byte, busy checked inside the frame.
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
    checkFrames("valid_55");

    // Parity error.
    applyStimulus(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0);
    checkFrames("parity_A3");

    // Framing error on STOP2 immediately followed by a clean frame.
    applyStimulus(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    checkFrames("b2b");

    // One-clock glitch: the receiver wakes up, then drops back to idle.
    bus.prdata = 1'b0;
    @(posedge clk);
    #1;
    bus.prdata = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("glitch_busy_high", int'(bus.busy), 1);
    idleBits(4);
    checkOutput("glitch_rend_count", obs_data.size(), 0);
    checkOutput("glitch_busy_low", int'(bus.busy), 0);

    // Abort by dropping ren after the 4th data bit.
    rd = 8'h5A;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(rd[i]);
    bus.ren = 1'b0;
    bus.prdata = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.ren = 1'b1;
    idleBits(14);
    checkOutput("abort_rend_count", obs_data.size(), 0);
    checkOutput("abort_busy", int'(bus.busy), 0);
    checkOutput("abort_o_data", bus.o_data, last_data);
    checkOutput("abort_perr", int'(bus.perr), int'(last_perr));
    checkOutput("abort_ferr", int'(bus.ferr), int'(last_ferr));

    // Reset in the middle of DATA.
    rd = 8'h96;
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(rd[i]);
    rst = 1'b1;
    bus.prdata = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdleOutputs("mid_reset");
    last_data = 8'h00; last_perr = 1'b0; last_ferr = 1'b0;
    idleBits(13);
    checkOutput("mid_reset_rend_count", obs_data.size(), 0);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    checkFrames("after_reset_3C");

    // Random frames with random parity/stop bits and gaps.
    for (int n = 0; n < 10; n++) begin
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 3) != 0);
      if (rd == 8'h00 && !rp) r1 = 1'b1;
      applyStimulus(rd, rp, r1, r2, 1'b0);
      if (!r2) idleBits(0);
      else idleBits($urandom_range(0, 2));
    end
    idleBits(2);
    checkFrames("random");

    // Line held low for 14 bit periods, then released.
    brk_cnt = 0;
    bus.prdata = 1'b0;
    repeat (14 * CPB) @(posedge clk);
    #1;
`ifdef UPDI_RX_BREAK_DET_EN
    checkOutput("break_no_early_brk", brk_cnt, 0);
`endif
    idleBits(4);
`ifdef UPDI_RX_BREAK_DET_EN
    checkOutput("break_brk_count", brk_cnt, 1);
    checkOutput("break_rend_count", obs_data.size(), 0);
    checkOutput("break_o_data", bus.o_data, last_data);
    checkOutput("break_perr", int'(bus.perr), int'(last_perr));
    checkOutput("break_ferr", int'(bus.ferr), int'(last_ferr));
`else
    checkOutput("break_brk_count", brk_cnt, 0);
    checkOutput("break_rend_count", obs_data.size(), 1);
    if (obs_data.size() != 0) begin
      checkOutput("break_o_data", obs_data[0], 8'h00);
      checkOutput("break_perr", int'(obs_perr[0]), 0);
      checkOutput("break_ferr", int'(obs_ferr[0]), 1);
    end
`endif
    bus.ren = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.ren = 1'b1;
    idleBits(2);
    checkOutput("final_busy", int'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/updi_phy_rx.md
Name: updi_phy_rx

Overview:
- Receive half of the UPDI physical layer. It deserializes the single-wire UPDI frame on `prdata`: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 2 stop bits (1), with the line idling high.
- It delivers the received byte with parity and framing status and a one-cycle `rend` strobe to the UPDI link/data layer.
- It is the counterpart of the PHY transmitter that drives `pwdata` and pulses `tend`.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UPDI bit. Must be an even integer >= 4.
- HALF_BIT, CLKS_PER_BIT/2, derived; cycles from the start-bit edge to its mid-bit sample. Do not override.

Ports:
- clk     input   1  system clock; all logic is on the rising edge
- rst     input   1  reset, synchronous, active-high
- ren     input   1  receive enable; low holds the block in IDLE
- prdata  input   1  asynchronous serial UPDI line, idle high
- o_data  output  8  last received byte
- rend    output  1  one-cycle strobe: frame complete; o_data, perr and ferr are valid
- perr    output  1  parity error on the last frame
- ferr    output  1  framing error on the last frame (either stop bit sampled 0)
- busy    output  1  high in every state except IDLE
- brk     output  1  one-cycle break-detected strobe; tied 0 when the feature is compiled out

Behaviour:
- Reset: o_data=8'h00; rend=perr=ferr=busy=brk=0; both synchronizer flops=1; state=IDLE; bit counter and clock counter=0.
- Synchronizer: `prdata` passes through 2 flops, giving rx_s. Only rx_s is used internally.
- IDLE:
  - Entered when ren=1 and rx_s=0 → START, clock counter cleared.
  - With ren=0 the block ignores the line.
- START:
  - At clock count HALF_BIT-1, sample rx_s.
  - rx_s=1 → glitch: return to IDLE; no strobe, flags unchanged.
  - rx_s=0 → DATA; clock counter cleared.
- DATA:
  - Sample rx_s every CLKS_PER_BIT cycles, at mid-bit.
  - Shift into bit [7] of the shift register, shifting right, so bit 0 is received first.
  - After 8 samples → PARITY.
- PARITY:
  - Sample one bit.
  - Parity error = (sampled bit != XOR of the 8 data bits), i.e. even parity.
- STOP1, then STOP2:
  - Sample one bit in each state.
  - Either sample 0 sets the framing error.
- Frame end: on the cycle after the STOP2 sample, in a single cycle:
  - o_data is loaded from the shift register.
  - perr and ferr are loaded.
  - rend=1 for exactly that cycle.
  - The state returns to IDLE.
  - No wait for the end of the stop bit; this allows back-to-back frames.
- Flag hold: perr and ferr hold their values until the next rend.
- Latency: nominal time from the prdata falling edge to rend is 11.5 bit periods + 3 clk. The bench tolerance is ±1 clk.
- ren deasserted mid-frame: abort to IDLE on the next edge. No rend; o_data and flags keep their old values.
- rst mid-frame: all registers return to their reset values on the next edge; the partial frame is discarded.
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle.
- busy: a registered decode of state != IDLE.
- Counter wrap: the clock counter resets at every bit boundary. The bit counter covers 0..7 only, in DATA.

Optional Feature:
- Macro: UPDI_RX_BREAK_DET_EN. It controls UPDI BREAK detection (line held low for at least 12 bit periods).
- Enabled:
  - Break condition: all 8 data bits are 0, the parity sample is 0, and the STOP1 sample is 0. The block then enters state BREAK; rend is not asserted.
  - BREAK state: wait until rx_s=1.
  - On that cycle: brk=1 for one cycle; o_data, perr and ferr are unchanged; return to IDLE.
  - ren=0 or rst while in BREAK returns to IDLE with no brk pulse.
- Disabled:
  - The BREAK state is absent and brk is tied 0.
  - The same line condition completes as a normal frame: o_data=8'h00, perr=0, ferr=1, rend pulsed.

Test Plan:
- Valid byte: CLKS_PER_BIT=4, ren=1, drive 0x55 with parity 0 and two stop bits → one rend, o_data=8'h55, perr=0, ferr=0; busy high through the frame.
- Parity error: drive 0xA3 with parity bit 1 (correct is 0) → rend, o_data=8'hA3, perr=1, ferr=0.
- Framing error and back-to-back: drive 0x0F with STOP2=0, then 0xFF immediately after.
  - Frame 1 → o_data=8'h0F, ferr=1.
  - Frame 2 → o_data=8'hFF, perr=0, ferr=0; exactly 2 rend pulses.
- Glitch and abort:
  - A 1-clk low pulse on prdata → no rend, busy returns to 0.
  - Dropping ren after the 4th data bit → no rend; o_data still equals the previous value.
- Reset mid-frame: assert rst for 1 cycle during the DATA state → all outputs 0 and busy=0. The next clean frame 0x3C → o_data=8'h3C.
- Break, with UPDI_RX_BREAK_DET_EN: prdata low for 14 bit periods, then high → exactly one brk pulse when the line returns high, no rend.
  - Without the macro: one rend with o_data=8'h00, ferr=1; brk stays 0.
